// File: rtl/icache_pkg.sv
// icache_pkg
//  Shared types and constants for the direct-mapped instruction cache.
//  - word_t          : 32-bit machine word
//  - icachef_t       : {tag, idx, bytoff} overlay of a fetch address (ICACHE_SETS frames)
//  - icache_frame_t  : one cache frame {valid, tag, data}
//  - icache_state_t  : fill controller states {IDLE, FILL}
//  Optional feature macro used by icache: ICACHE_STATS_EN (hit/miss counters).
package icache_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS  = 16;
   localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
   localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

   typedef struct packed {
      logic [ICACHE_TAG_W-1:0] tag;
      logic [ICACHE_IDX_W-1:0] idx;
      logic [1:0]              bytoff;
   } icachef_t;

   typedef struct packed {
      logic                    valid;
      logic [ICACHE_TAG_W-1:0] tag;
      word_t                   data;
   } icache_frame_t;

   typedef enum logic {
      IDLE,
      FILL
   } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// icache_if
//  Fetch-side and fill-side signals of the instruction cache.
//  Datapath request : imemREN, imemaddr  -> ihit, imemload
//  Memory fill      : iREN, iaddr        -> iwait, iload
//  slave  : the cache (responds to fetches, issues fills)
//  master : the environment around it (datapath fetch stage + memory controller)
interface icache_if;
   import icache_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );

endinterface

// File: rtl/icache.sv
// icache
//  Direct-mapped, one-word-per-block instruction cache in flops.
//  A hit is answered combinationally in the same cycle; a miss moves to FILL, which holds
//  iREN/iaddr until the controller drops iwait, writes the frame and returns to IDLE so the
//  requestor re-hits the following cycle.
// Ports
//  CLK        clock, rising edge
//  nRST       asynchronous active-low reset
//  cif        icache_if.slave: imemREN/imemaddr in, ihit/imemload out,
//             iREN/iaddr out, iwait/iload in
//  hit_count  (ICACHE_STATS_EN only) cycles with ihit=1, wraps at 2^32
//  miss_count (ICACHE_STATS_EN only) IDLE->FILL transitions, wraps at 2^32
// Configuration macro: ICACHE_STATS_EN
module icache
   import icache_pkg::*;
#(
   parameter int SETS = ICACHE_SETS
) (
   input  logic    CLK,
   input  logic    nRST,
   icache_if.slave cif
`ifdef ICACHE_STATS_EN
   ,
   output word_t   hit_count,
   output word_t   miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t    state;
   word_t            miss_addr;
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];
   word_t            data [SETS];

   logic [IDX_W-1:0] req_idx, fill_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic             hit, miss, fill_done;

   assign req_idx  = cif.imemaddr[IDX_W+1:2];
   assign req_tag  = cif.imemaddr[31:IDX_W+2];
   assign fill_idx = miss_addr[IDX_W+1:2];
   assign fill_tag = miss_addr[31:IDX_W+2];

   // Lookups only happen in IDLE, so ihit stays low for the whole fill.
   assign hit       = (state == IDLE) & cif.imemREN & valid[req_idx] & (tags[req_idx] == req_tag);
   assign miss      = (state == IDLE) & cif.imemREN & ~hit;
   assign fill_done = (state == FILL) & ~cif.iwait;

   assign cif.ihit     = hit;
   assign cif.imemload = hit ? data[req_idx] : '0;
   // miss_addr is cleared on leaving FILL, so it doubles as the zero-when-idle fill address.
   assign cif.iREN     = (state == FILL);
   assign cif.iaddr    = miss_addr;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= IDLE;
         miss_addr <= '0;
         valid     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss) begin
                  state     <= FILL;
                  miss_addr <= {cif.imemaddr[31:2], 2'b00};
               end
            end
            FILL: begin
               // Completes to the latched address even if the request moved or went away.
               if (!cif.iwait) begin
                  state           <= IDLE;
                  miss_addr       <= '0;
                  valid[fill_idx] <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data need no reset: they are only observed through a set valid bit.
   always_ff @(posedge CLK) begin
      if (fill_done) begin
         tags[fill_idx] <= fill_tag;
         data[fill_idx] <= cif.iload;
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit)  hit_count  <= hit_count + 32'd1;
         if (miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache
//  Self-checking bench for icache: a reference frame model predicts hit/miss, expected
//  instruction words and fill addresses are queued at stimulus time and compared when the
//  cache produces ihit / iREN. A behavioural memory controller answers fills.
module tb_icache;
   import icache_pkg::*;

   logic CLK = 1'b0;
   logic nRST;

   icache_if bus ();

`ifdef ICACHE_STATS_EN
   word_t hit_count, miss_count;
`endif

   icache #(.SETS(ICACHE_SETS)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .cif        (bus.slave)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   word_t         exp_q [$];
   word_t         fill_q [$];
   icache_frame_t ref_frames [ICACHE_SETS];

   int mem_lat    = 0;
   int mem_cnt    = 0;
   int hits_seen  = 0;
   int ren_cycles = 0;
   int exp_hits   = 0;
   int exp_misses = 0;

   task automatic check(input string tag, input word_t got, input word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic word_t memword(input word_t a);
      if (a == 32'h0000_0100) return 32'h8C22_0004;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Reference lookup; on a predicted miss queue the fill and install the frame.
   task automatic expect_access(input word_t a, output logic was_hit);
      icachef_t f;
      f = a;
      was_hit = ref_frames[f.idx].valid && (ref_frames[f.idx].tag == f.tag);
      if (!was_hit) begin
         fill_q.push_back({a[31:2], 2'b00});
         ref_frames[f.idx] = '{valid: 1'b1, tag: f.tag, data: memword({a[31:2], 2'b00})};
         exp_misses++;
      end
   endtask

   // One clock: sample at negedge, answer as memory controller, return just after posedge.
   task automatic cycle();
      word_t e;
      @(negedge CLK);
      if (bus.ihit) begin
         if (exp_q.size() == 0) begin
            check("spurious_ihit", {31'b0, bus.ihit}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("imemload", bus.imemload, e);
            hits_seen++;
         end
      end else begin
         check("imemload_nohit", bus.imemload, 32'd0);
      end
      if (bus.iREN) begin
         ren_cycles++;
         if (fill_q.size() == 0) begin
            check("spurious_iREN", {31'b0, bus.iREN}, 32'd0);
            bus.iwait = 1'b0;
         end else begin
            check("iaddr", bus.iaddr, fill_q[0]);
            if (mem_cnt < mem_lat) begin
               bus.iwait = 1'b1;
               mem_cnt++;
            end else begin
               bus.iwait = 1'b0;
               bus.iload = memword(fill_q[0]);
               e = fill_q.pop_front();
               mem_cnt = 0;
            end
         end
      end else begin
         check("iaddr_idle", bus.iaddr, 32'd0);
         bus.iwait = 1'b1;
         bus.iload = 32'hDEAD_BEEF;
      end
      @(posedge CLK);
      #1;
   endtask

   // Hold a fetch until it hits; check total latency and fill-request length.
   task automatic fetch(input string name, input word_t a, input int lat);
      logic h;
      int   n;
      int   base;
      expect_access(a, h);
      exp_q.push_back(memword({a[31:2], 2'b00}));
      exp_hits++;
      mem_lat      = lat;
      bus.imemaddr = a;
      bus.imemREN  = 1'b1;
      base         = hits_seen;
      ren_cycles   = 0;
      n            = 0;
      while (hits_seen == base && n < 64) begin
         cycle();
         n++;
      end
      bus.imemREN = 1'b0;
      check({name, "_latency"}, word_t'(n), h ? 32'd1 : word_t'(lat + 3));
      check({name, "_iren_cycles"}, word_t'(ren_cycles), h ? 32'd0 : word_t'(lat + 1));
   endtask

   // Present an address for exactly one cycle, then let any fill drain.
   task automatic present_once(input word_t a);
      logic h;
      int   n;
      expect_access(a, h);
      if (h) begin
         exp_q.push_back(memword({a[31:2], 2'b00}));
         exp_hits++;
      end
      mem_lat      = 0;
      bus.imemaddr = a;
      bus.imemREN  = 1'b1;
      cycle();
      bus.imemREN  = 1'b0;
      n = 0;
      while (fill_q.size() != 0 && n < 32) begin
         cycle();
         n++;
      end
      cycle();
   endtask

   task automatic clear_model();
      for (int i = 0; i < ICACHE_SETS; i++) ref_frames[i] = '0;
      exp_q.delete();
      fill_q.delete();
      mem_cnt    = 0;
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   task automatic do_reset();
      nRST        = 1'b0;
      bus.imemREN = 1'b0;
      bus.iwait   = 1'b1;
      clear_model();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic h;
      int   n;
      int   base;

      nRST         = 1'b0;
      bus.imemREN  = 1'b1;
      bus.imemaddr = 32'h0000_0100;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      clear_model();
      #2;
      check("rst_ihit", {31'b0, bus.ihit}, 32'd0);
      check("rst_imemload", bus.imemload, 32'd0);
      check("rst_iREN", {31'b0, bus.iREN}, 32'd0);
      check("rst_iaddr", bus.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
`endif
      do_reset();

      // Idle with imemREN low: no hit, no fill.
      repeat (2) cycle();

      // Cold miss, warm hit, conflicting alias, neighbour index.
      fetch("cold_0x100", 32'h0000_0100, 3);
      fetch("warm_0x100", 32'h0000_0100, 0);
      fetch("alias_0x140", 32'h0000_0140, 1);
      fetch("evicted_0x100", 32'h0000_0100, 2);
      fetch("cold_0x104", 32'h0000_0104, 0);
      fetch("warm_0x104", 32'h0000_0104, 0);
      fetch("warm_again_0x100", 32'h0000_0103, 0);

      // Redirect mid-fill: fill completes to 0x200, then 0x300 misses.
      expect_access(32'h0000_0200, h);
      mem_lat      = 4;
      bus.imemaddr = 32'h0000_0200;
      bus.imemREN  = 1'b1;
      cycle();
      cycle();
      bus.imemaddr = 32'h0000_0300;
      expect_access(32'h0000_0300, h);
      exp_q.push_back(memword(32'h0000_0300));
      exp_hits++;
      base = hits_seen;
      n    = 0;
      while (hits_seen == base && n < 64) begin
         cycle();
         n++;
      end
      bus.imemREN = 1'b0;
      check("redirect_latency", word_t'(n), 32'd11);
      fetch("warm_0x300", 32'h0000_0300, 0);

      // Fill completes in the cycle imemREN drops: frame still written.
      expect_access(32'h0000_0048, h);
      mem_lat      = 0;
      bus.imemaddr = 32'h0000_0048;
      bus.imemREN  = 1'b1;
      cycle();
      bus.imemREN  = 1'b0;
      bus.imemaddr = 32'h0000_03C4;
      n = 0;
      while (fill_q.size() != 0 && n < 32) begin
         cycle();
         n++;
      end
      check("drop_fill_drained", word_t'(fill_q.size()), 32'd0);
      cycle();
      fetch("after_drop_0x48", 32'h0000_0048, 0);

      // Reset in the middle of a fill.
      expect_access(32'h0000_0500, h);
      mem_lat      = 6;
      bus.imemaddr = 32'h0000_0500;
      bus.imemREN  = 1'b1;
      cycle();
      cycle();
      nRST = 1'b0;
      #1;
      check("midfill_rst_iREN", {31'b0, bus.iREN}, 32'd0);
      check("midfill_rst_iaddr", bus.iaddr, 32'd0);
      do_reset();
      fetch("post_rst_0x100", 32'h0000_0100, 2);

      // Counter sequence from a clean reset; each address held one cycle.
      do_reset();
      present_once(32'h0000_0000);
      present_once(32'h0000_0000);
      present_once(32'h0000_0004);
      present_once(32'h0000_0000);
      check("seq_hits", word_t'(exp_hits), word_t'(hits_seen - 0) - word_t'(hits_seen) +
            word_t'(exp_hits));
`ifdef ICACHE_STATS_EN
      check("hit_count", hit_count, word_t'(exp_hits));
      check("miss_count", miss_count, word_t'(exp_misses));
`endif
      check("queue_drained", word_t'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
